reg_bus_xfer_ctrl: RTL and testbench



---
 rtl/reg_bus_xfer_ctrl.sv | 110 +++++++++++
 tb/tb_reg_bus_xfer_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_xfer_ctrl.sv
`timescale 1ns/1ps
// reg_bus_xfer_ctrl: initiator side of the 8-bit tri-state register bus.
// Sequences one register->register or immediate->register move per request.
module reg_bus_xfer_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                clk50M_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [SEL_W-1:0]    src_i,
  input  logic [SEL_W-1:0]    dst_i,
  input  logic                imm_i,
  input  logic [7:0]          imm_dat_i,
  output logic [NUM_REGS-1:0] rd_en_o,
  output logic [NUM_REGS-1:0] wr_en_o,
  inout  wire  [7:0]          bus_io,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          xfer_dat_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] src_q;
  logic [SEL_W-1:0] dst_q;
  logic             imm_q;
  logic [7:0]       imm_dat_q;
  logic [7:0]       xfer_dat_q;
  logic             err_q;
  logic             illegal;
  logic             accept;
  logic             drive;

  always_comb begin
    illegal = 1'b0;
    if (int'(dst_i) >= NUM_REGS)
      illegal = 1'b1;
    if (!imm_i && (int'(src_i) >= NUM_REGS || src_i == dst_i))
      illegal = 1'b1;
  end

  assign accept = (state == IDLE) && req_i;

  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (req_i) state_nxt = illegal ? DONE : SETUP;
      SETUP: state_nxt = XFER;
      XFER:  state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q      <= '0;
      dst_q      <= '0;
      imm_q      <= 1'b0;
      imm_dat_q  <= 8'h00;
      err_q      <= 1'b0;
      xfer_dat_q <= 8'h00;
    end else begin
      if (accept) begin
        src_q     <= src_i;
        dst_q     <= dst_i;
        imm_q     <= imm_i;
        imm_dat_q <= imm_dat_i;
        err_q     <= illegal;
      end
      // destination captures on this same edge
      if (state == XFER)
        xfer_dat_q <= bus_io;
    end
  end

  assign drive = (state == SETUP) || (state == XFER);

  always_comb begin
    rd_en_o = '0;
    wr_en_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_en_o[i] = drive && !imm_q && (src_q == SEL_W'(i));
      wr_en_o[i] = (state == XFER) && (dst_q == SEL_W'(i));
    end
  end

  assign bus_io     = (drive && imm_q) ? imm_dat_q : 8'hzz;
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);
  assign err_o      = (state == DONE) && err_q;
  assign xfer_dat_o = xfer_dat_q;

endmodule

// File: tb/tb_reg_bus_xfer_ctrl.sv
`timescale 1ns/1ps
// tb_reg_bus_xfer_ctrl: random + directed transfers against a register
// file model; a monitor scores every cycle of every transfer.
module tb_reg_bus_xfer_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req = 1'b0;
  logic [2:0]   src = '0;
  logic [2:0]   dst = '0;
  logic         imm = 1'b0;
  logic [7:0]   imm_dat = '0;
  logic [N-1:0] rd_en;
  logic [N-1:0] wr_en;
  logic [7:0]   xfer_dat;
  logic         busy;
  logic         done;
  logic         err;
  logic         fin = 1'b0;
  wire  [7:0]   bus;

  logic [7:0] regs [N];
  logic [7:0] model [N];
  logic [7:0] last_xfer;
  logic [7:0] rd_val;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;

  typedef struct {
    logic [2:0] src;
    logic [2:0] dst;
    logic       imm;
    logic [7:0] dat;
    int         acc;
  } req_t;

  req_t q[$];

  always #10 clk = ~clk;

  reg_bus_xfer_ctrl #(.NUM_REGS(N), .SEL_W(3)) dut (
    .clk50M_i  (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .src_i     (src),
    .dst_i     (dst),
    .imm_i     (imm),
    .imm_dat_i (imm_dat),
    .rd_en_o   (rd_en),
    .wr_en_o   (wr_en),
    .bus_io    (bus),
    .busy_o    (busy),
    .done_o    (done),
    .xfer_dat_o(xfer_dat),
    .err_o     (err)
  );

  // bus-attached registers
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N; i++)
      if (rd_en[i]) rd_val = rd_val | regs[i];
  end

  assign bus = (rd_en != '0) ? rd_val : 8'hzz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc < 2) begin
      for (int i = 0; i < N; i++) regs[i] <= model[i];
    end else begin
      for (int i = 0; i < N; i++)
        if (wr_en[i]) regs[i] <= bus;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp)
      passes++;
    else
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
  endtask

  // monitor / scoreboard
  initial begin
    req_t       e;
    int         off;
    logic       bad;
    logic       popq;
    logic [7:0] val;
    logic [7:0] exp_rd, exp_wr, exp_x;
    logic       exp_done, exp_err, exp_busy;
    for (int i = 0; i < N; i++) model[i] = 8'($urandom);
    model[2] = 8'hA5;
    last_xfer = 8'h00;
    forever begin
      @(negedge clk or negedge rst_n or posedge fin);
      if (fin) begin
        chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
      end
      if (!rst_n) begin
        #1;
        q.delete();
        last_xfer = 8'h00;
        chk("rst_rd", rd_en, 0);
        chk("rst_wr", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_xfer", xfer_dat, 0);
        continue;
      end
      exp_rd = '0; exp_wr = '0; exp_done = 0; exp_err = 0;
      exp_busy = 0; exp_x = last_xfer; popq = 0; bad = 0; val = '0;
      if (q.size() != 0) begin
        e = q[0];
        off = cyc - e.acc;
        exp_busy = 1;
        bad = (int'(e.dst) >= N) ||
              (!e.imm && (int'(e.src) >= N || e.src == e.dst));
        if (bad) begin
          exp_done = 1; exp_err = 1; popq = 1;
          chk("lat_err", off, 0);
        end else begin
          val = e.imm ? e.dat : model[e.src];
          if (off < 2 && !e.imm) exp_rd = 8'd1 << e.src;
          if (off == 1) exp_wr = 8'd1 << e.dst;
          if (off < 2 && e.imm) chk("bus_imm", bus, e.dat);
          if (off >= 2) begin
            exp_done = 1; exp_x = val; popq = 1;
            chk("lat_done", off, 2);
            chk("dst_reg", regs[e.dst], val);
          end
        end
      end
      chk("rd_en", rd_en, exp_rd);
      chk("wr_en", wr_en, exp_wr);
      chk("done", done, exp_done);
      chk("err", err, exp_err);
      chk("busy", busy, exp_busy);
      chk("xfer_dat", xfer_dat, exp_x);
      if (popq) begin
        void'(q.pop_front());
        if (!bad) begin
          model[e.dst] = val;
          last_xfer = val;
        end
      end
      if (!busy && req)
        q.push_back('{src, dst, imm, imm_dat, cyc + 1});
    end
  end

  task automatic issue(input logic [2:0] s, input logic [2:0] d,
                       input logic im, input logic [7:0] dt,
                       input int hold, input bit scr);
    int n = 0;
    @(posedge clk); #2;
    while (busy && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    if (busy) begin
      $display("FAIL issue_timeout: busy stuck high (cycle %0d)", cyc);
      $fatal(1);
    end
    src = s; dst = d; imm = im; imm_dat = dt; req = 1'b1;
    @(posedge clk); #2;
    repeat (hold) begin
      if (scr) begin
        src = 3'($urandom); dst = 3'($urandom);
        imm = 1'($urandom); imm_dat = 8'($urandom);
      end
      @(posedge clk); #2;
    end
    req = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(3'd2, 3'd5, 1'b0, 8'h00, 0, 0);
    issue(3'd0, 3'd7, 1'b1, 8'h3C, 0, 0);
    issue(3'd4, 3'd4, 1'b0, 8'h00, 0, 0);
    issue(3'd1, 3'd3, 1'b0, 8'h00, 13, 0);
    // abort mid-XFER
    issue(3'd6, 3'd0, 1'b0, 8'h00, 0, 0);
    @(posedge clk); #4;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(3'd2, 3'd5, 1'b0, 8'h00, 0, 0);
    issue(3'd5, 3'd1, 1'b0, 8'h00, 0, 0);
    repeat (150) begin
      logic [2:0] s, d;
      s = 3'($urandom);
      d = 3'($urandom);
      if ($urandom_range(3) == 0) d = s;
      issue(s, d, ($urandom_range(2) == 0), 8'($urandom),
            $urandom_range(2), 1);
      repeat ($urandom_range(2)) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    #2 fin = 1'b1;
  end

endmodule
